// File: rtl/logical_tile_clb_mode_frac__fle_param.sv
// Fracturable logic element for the clb tile.
//  - K-input LUT, splittable into two (K-1)-LUTs, or an arithmetic slice
//    driving the cin -> cout chain combinationally.
//  - Two output FFs with enable and per-output bypass; they double as a
//    two-bit scan chain (fle_sc_in -> ff[0] -> ff[1] -> fle_sc_out).
//  - Configuration lives in a serial ccff chain clocked by fle_clk.
// Optional feature macro: FLE_CFG_PARITY_EN adds an even-parity bit at the
// top of the config chain and a sticky, registered cfg_err output.
module logical_tile_clb_mode_frac__fle_param #(
  parameter int K = 6
) (
  input  logic         fle_clk,
  input  logic         fle_reset,
  input  logic         config_enable,
  input  logic         ccff_head,
  input  logic [K-1:0] fle_in,
  input  logic         fle_cin,
  input  logic         fle_sc_en,
  input  logic         fle_sc_in,
  input  logic         fle_enable,
  output logic [1:0]   fle_out,
  output logic         fle_cout,
  output logic         fle_sc_out,
  output logic         ccff_tail
`ifdef FLE_CFG_PARITY_EN
  ,
  output logic         cfg_err
`endif
);

  localparam int MASK_W = 2 ** K;
  localparam int HALF_W = 2 ** (K - 1);
`ifdef FLE_CFG_PARITY_EN
  localparam int CFG_W  = MASK_W + 5;
`else
  localparam int CFG_W  = MASK_W + 4;
`endif

  // Config chain and user FFs
  logic [CFG_W-1:0]  cfg_q, cfg_d;
  logic [1:0]        ff_q, ff_d;

  // Decoded configuration fields
  logic [MASK_W-1:0] lut_mask;
  logic [HALF_W-1:0] lut_lo;
  logic [HALF_W-1:0] lut_hi;
  logic              frac;
  logic              arith;
  logic [1:0]        bypass;
  logic [K-2:0]      half_idx;

  assign lut_mask = cfg_q[MASK_W-1:0];
  assign lut_lo   = cfg_q[HALF_W-1:0];
  assign lut_hi   = cfg_q[MASK_W-1:HALF_W];
  assign frac     = cfg_q[MASK_W];
  assign arith    = cfg_q[MASK_W+1];
  assign bypass   = cfg_q[MASK_W+3:MASK_W+2];
  assign half_idx = fle_in[K-2:0];

  // LUT results and carry
  logic [1:0] lut_c;
  logic       carry_out;
  logic       prop;
  logic       gen;

  // LUT evaluation: arithmetic overrides fracture; carry is zero outside arith
  always_comb begin
    lut_c     = 2'b00;
    carry_out = 1'b0;
    prop      = 1'b0;
    gen       = 1'b0;
    if (arith) begin
      prop      = lut_lo[half_idx];
      gen       = lut_hi[half_idx];
      lut_c[0]  = prop ^ fle_cin;
      lut_c[1]  = gen;
      carry_out = prop ? fle_cin : gen;
    end else if (frac) begin
      lut_c = {lut_hi[half_idx], lut_lo[half_idx]};
    end else begin
      lut_c = {2{lut_mask[fle_in]}};
    end
  end

  // Next-state for config chain and FFs (config shift freezes user FFs)
  always_comb begin
    cfg_d = cfg_q;
    ff_d  = ff_q;
    if (config_enable) begin
      cfg_d = {cfg_q[CFG_W-2:0], ccff_head};
    end else if (fle_sc_en) begin
      ff_d = {ff_q[0], fle_sc_in};
    end else if (fle_enable) begin
      ff_d = lut_c;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge fle_clk) begin
    if (fle_reset) begin
      cfg_q <= '0;
      ff_q  <= 2'b00;
    end else begin
      cfg_q <= cfg_d;
      ff_q  <= ff_d;
    end
  end

  // Output mux: bypass selects combinational LUT, forced low while configuring
  always_comb begin
    fle_out  = 2'b00;
    fle_cout = 1'b0;
    if (!config_enable) begin
      for (int i = 0; i < 2; i++) begin
        fle_out[i] = bypass[i] ? lut_c[i] : ff_q[i];
      end
      fle_cout = carry_out;
    end
  end

  assign fle_sc_out = ff_q[1];
  assign ccff_tail  = cfg_q[CFG_W-1];

`ifdef FLE_CFG_PARITY_EN
  logic cfg_err_q, cfg_err_d;

  // Sticky parity flag; cleared by any config shift cycle
  always_comb begin
    cfg_err_d = cfg_err_q;
    if (config_enable) begin
      cfg_err_d = 1'b0;
    end else if (^cfg_q) begin
      cfg_err_d = 1'b1;
    end
  end

  // Parity flag register
  always_ff @(posedge fle_clk) begin
    if (fle_reset) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;
`endif

endmodule

// File: tb/tb_logical_tile_clb_mode_frac__fle_param.sv
// Scoreboard bench for logical_tile_clb_mode_frac__fle_param (K=6).
// Expected values are queued as stimulus is applied and compared when sampled.
module tb_logical_tile_clb_mode_frac__fle_param;

  localparam int K = 6;
`ifdef FLE_CFG_PARITY_EN
  localparam int CFG_W = 69;
`else
  localparam int CFG_W = 68;
`endif

  localparam int S_OUT  = 0;
  localparam int S_COUT = 1;
  localparam int S_SC   = 2;
  localparam int S_TAIL = 3;
  localparam int S_ERR  = 4;

  logic         clk;
  logic         rst;
  logic         config_enable;
  logic         ccff_head;
  logic [K-1:0] fle_in;
  logic         fle_cin;
  logic         fle_sc_en;
  logic         fle_sc_in;
  logic         fle_enable;
  logic [1:0]   fle_out;
  logic         fle_cout;
  logic         fle_sc_out;
  logic         ccff_tail;
  logic         cfg_err_w;

  logical_tile_clb_mode_frac__fle_param #(.K(K)) dut (
    .fle_clk       (clk),
    .fle_reset     (rst),
    .config_enable (config_enable),
    .ccff_head     (ccff_head),
    .fle_in        (fle_in),
    .fle_cin       (fle_cin),
    .fle_sc_en     (fle_sc_en),
    .fle_sc_in     (fle_sc_in),
    .fle_enable    (fle_enable),
    .fle_out       (fle_out),
    .fle_cout      (fle_cout),
    .fle_sc_out    (fle_sc_out),
    .ccff_tail     (ccff_tail)
`ifdef FLE_CFG_PARITY_EN
    ,
    .cfg_err       (cfg_err_w)
`endif
  );

`ifndef FLE_CFG_PARITY_EN
  assign cfg_err_w = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    int         sig;
    logic [1:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic check_val(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int sig, input logic [1:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb_q.push_back(e);
  endtask

  function automatic logic [1:0] observe(input int sig);
    case (sig)
      S_OUT:   return fle_out;
      S_COUT:  return {1'b0, fle_cout};
      S_SC:    return {1'b0, fle_sc_out};
      S_TAIL:  return {1'b0, ccff_tail};
      default: return {1'b0, cfg_err_w};
    endcase
  endfunction

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.sig), e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CFG_W-1:0] make_frame(input logic [63:0] mask, input logic frac,
                                                  input logic arith, input logic [1:0] byp);
    logic [CFG_W-1:0] f;
    f        = '0;
    f[63:0]  = mask;
    f[64]    = frac;
    f[65]    = arith;
    f[67:66] = byp;
`ifdef FLE_CFG_PARITY_EN
    f[68]    = ^f[67:0];
`endif
    return f;
  endfunction

  // Shift n bits of frame, starting at the given position from the top bit
  task automatic shift_bits(input logic [CFG_W-1:0] frame, input int start, input int n);
    config_enable = 1'b1;
    for (int k = 0; k < n; k++) begin
      ccff_head = frame[CFG_W-1-(start+k)];
      tick();
    end
  endtask

  task automatic load_frame(input logic [CFG_W-1:0] frame);
    shift_bits(frame, 0, CFG_W);
    config_enable = 1'b0;
    ccff_head     = 1'b0;
  endtask

  logic [CFG_W-1:0] frame;
  logic [63:0]      rmask;
  logic [K-1:0]     idx;
  logic             tail_any;

  initial begin
    rst = 1'b1; config_enable = 1'b0; ccff_head = 1'b0; fle_in = '0; fle_cin = 1'b0;
    fle_sc_en = 1'b0; fle_sc_in = 1'b0; fle_enable = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    push_exp("rst_out", S_OUT, 2'b00);
    push_exp("rst_cout", S_COUT, 2'b00);
    push_exp("rst_sc", S_SC, 2'b00);
    push_exp("rst_tail", S_TAIL, 2'b00);
    push_exp("rst_err", S_ERR, 2'b00);
    drain();

    // Plain 6-LUT, both outputs bypassed
    frame = make_frame(64'h8000_0000_0000_0000, 1'b0, 1'b0, 2'b11);
    fle_in = 6'h3F; fle_cin = 1'b1;
    shift_bits(frame, 0, CFG_W - 1);
    push_exp("cfg_forced_out", S_OUT, 2'b00);
    push_exp("tail_early", S_TAIL, 2'b00);
    drain();
    shift_bits(frame, CFG_W - 1, 1);
    push_exp("tail_replay", S_TAIL, {1'b0, frame[CFG_W-1]});
    drain();
    config_enable = 1'b0;
    fle_in = 6'h3F; #1;
    push_exp("lut_3f", S_OUT, 2'b11);
    push_exp("lut_cout0", S_COUT, 2'b00);
    drain();
    fle_in = 6'h3E; #1;
    push_exp("lut_3e", S_OUT, 2'b00);
    drain();

    // Random masks, random indices
    rmask = {$urandom(), $urandom()};
    load_frame(make_frame(rmask, 1'b0, 1'b0, 2'b11));
    for (int i = 0; i < 6; i++) begin
      idx = 6'($urandom_range(0, 63));
      fle_in = idx; #1;
      push_exp($sformatf("lut_rnd%0d", i), S_OUT, {rmask[idx], rmask[idx]});
      drain();
    end

    // Fractured mode, registered outputs
    load_frame(make_frame({32'h0000_FFFF, 32'hFFFF_0000}, 1'b1, 1'b0, 2'b00));
    fle_enable = 1'b1; fle_in = 6'h10;
    tick();
    push_exp("frac_10", S_OUT, 2'b01);
    drain();
    fle_enable = 1'b0; fle_in = 6'h00;
    tick();
    push_exp("frac_hold", S_OUT, 2'b01);
    drain();
    fle_enable = 1'b1;
    tick();
    push_exp("frac_00", S_OUT, 2'b10);
    drain();

    // Arithmetic mode: p = a0^a1, g = a0&a1
    fle_enable = 1'b0;
    load_frame(make_frame({32'h8888_8888, 32'h6666_6666}, 1'b0, 1'b1, 2'b11));
    fle_in = 6'b000011; fle_cin = 1'b1; #1;
    push_exp("arith11_out0", S_OUT, 2'b11);
    push_exp("arith11_cout", S_COUT, 2'b01);
    drain();
    fle_in = 6'b000001; fle_cin = 1'b1; #1;
    push_exp("arith01_out", S_OUT, 2'b00);
    push_exp("arith01_cout", S_COUT, 2'b01);
    drain();
    fle_cin = 1'b0; #1;
    push_exp("arith01c0_out", S_OUT, 2'b01);
    push_exp("arith01c0_cout", S_COUT, 2'b00);
    drain();
    fle_in = 6'b000000; fle_cin = 1'b1; #1;
    push_exp("arith00_cout", S_COUT, 2'b00);
    drain();

    // Scan chain: ff currently 2'b10 from the fractured test
    frame = make_frame({32'h8888_8888, 32'h6666_6666}, 1'b0, 1'b1, 2'b11);
    fle_sc_en = 1'b1; fle_enable = 1'b1; fle_sc_in = 1'b1;
    tick();
    push_exp("scan_1", S_SC, 2'b00);
    drain();
    fle_sc_in = 1'b0;
    tick();
    push_exp("scan_2", S_SC, 2'b01);
    drain();
    fle_sc_in = 1'b1; config_enable = 1'b1; ccff_head = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      push_exp($sformatf("scan_hold%0d", k), S_SC, 2'b01);
      push_exp($sformatf("cfg_shift%0d", k), S_TAIL, {1'b0, frame[CFG_W-1-k]});
      push_exp($sformatf("cfg_out0_%0d", k), S_OUT, 2'b00);
      drain();
    end
    config_enable = 1'b0; fle_sc_en = 1'b0; fle_enable = 1'b0;

    // Reset in the middle of a config shift
    frame = make_frame(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 2'b11);
    shift_bits(frame, 0, 30);
    rst = 1'b1;
    tick();
    rst = 1'b0; config_enable = 1'b0; fle_in = 6'h3F; fle_cin = 1'b1; #1;
    push_exp("rstcfg_out", S_OUT, 2'b00);
    push_exp("rstcfg_cout", S_COUT, 2'b00);
    push_exp("rstcfg_sc", S_SC, 2'b00);
    push_exp("rstcfg_tail", S_TAIL, 2'b00);
    drain();
    tail_any = 1'b0;
    config_enable = 1'b1; ccff_head = 1'b0;
    for (int k = 0; k < CFG_W; k++) begin
      tick();
      tail_any = tail_any | ccff_tail;
    end
    config_enable = 1'b0;
    check_val("rstcfg_all_zero", {1'b0, tail_any}, 2'b00);

    // Reset during operation
    load_frame(make_frame(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 2'b00));
    fle_enable = 1'b1; fle_in = 6'h15;
    tick();
    push_exp("op_out", S_OUT, 2'b11);
    drain();
    tick();
    push_exp("op_sc", S_SC, 2'b01);
    drain();
    rst = 1'b1;
    tick();
    rst = 1'b0; fle_enable = 1'b0; #1;
    push_exp("rstop_out", S_OUT, 2'b00);
    push_exp("rstop_sc", S_SC, 2'b00);
    push_exp("rstop_tail", S_TAIL, 2'b00);
    drain();

`ifdef FLE_CFG_PARITY_EN
    // Bad parity frame, then corrected frame
    frame = make_frame(64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 2'b01);
    frame[CFG_W-1] = ~frame[CFG_W-1];
    load_frame(frame);
    push_exp("par_pre", S_ERR, 2'b00);
    drain();
    tick();
    push_exp("par_bad", S_ERR, 2'b01);
    drain();
    tick();
    push_exp("par_sticky", S_ERR, 2'b01);
    drain();
    load_frame(make_frame(64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 2'b01));
    tick();
    tick();
    push_exp("par_good", S_ERR, 2'b00);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
